sp_ram_fifo_ctrl: RTL

- Initiator-side controller that drives a single-port 256x8 block-RAM macro (ce/oce/wre/ad/din in, dout out) and presents it as a synchronous byte FIFO.
- Sits between a byte producer (e.g. keyboard/UART receive path) and a consumer (CPU port logic).
- The RAM port allows one access per cycle, so push and pop contend for it and are arbitrated round-robin.

---
 rtl/sp_ram_fifo_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/sp_ram_fifo_ctrl.sv
// Byte FIFO controller in front of a single-port 256x8 block RAM.
// Push and pop share the one RAM port. When both sides want the port in the
// same cycle, it goes round-robin, and last_grant records who had it last.
// The RAM is in bypass read mode, so a read issued at one edge has its data
// on ram_dout in the following cycle. That is the cycle where pop_valid pulses.
module sp_ram_fifo_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop_req,
    output logic          pop_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          last_grant;    // 0 = push had the port last, 1 = pop
    logic          push_elig;
    logic          pop_elig;
    logic          push_want;
    logic          pop_want;
    logic          push_fire;
    logic          pop_fire;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Neither side may reach the RAM while the controller is being flushed.
    assign push_elig = !full  && !reset && !clear;
    assign pop_elig  = !empty && !reset && !clear;
    assign push_want = push_valid && push_elig;
    assign pop_want  = pop_req    && pop_elig;

    // Under contention, the side opposite last_grant wins. Each ready is
    // built from the other side's request only, so a fire never loops back
    // into its own ready.
    assign push_ready = push_elig && (!pop_want  ||  last_grant);
    assign pop_ready  = pop_elig  && (!push_want || !last_grant);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_req    && pop_ready;

    assign ram_ce   = push_fire | pop_fire;
    assign ram_wre  = push_fire;
    assign ram_ad   = push_fire ? wptr : rptr;
    assign ram_din  = push_data;
    assign ram_oce  = 1'b1;
    assign pop_data = ram_dout;

    // Pointer, occupancy, arbitration history and read-valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            last_grant <= 1'b1;
            pop_valid  <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            pop_valid  <= 1'b0;
        end else begin
            pop_valid <= pop_fire;
            if (push_fire) begin
                wptr       <= wptr + PTR_ONE;
                count      <= count + CNT_ONE;
                last_grant <= 1'b0;
            end else if (pop_fire) begin
                rptr       <= rptr + PTR_ONE;
                count      <= count - CNT_ONE;
                last_grant <= 1'b1;
            end
        end
    end

endmodule
